// File: rtl/gaussian_stream_ctrl_if.sv
// Stream-side signal bundle of gaussian_stream_ctrl: upstream FIFO, Gaussian core
// and the downstream read port of the output FIFO.
interface gaussian_stream_ctrl_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_rd_en;
  logic [DATA_W-1:0] flt_din;
  logic              flt_en;
  logic [DATA_W-1:0] flt_dout;
  logic              out_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_empty;
  logic [CntW-1:0]   out_count;
  logic              frame_done;

  // Environment side: upstream FIFO, Gaussian core and downstream consumer.
  modport master (
    output in_valid, in_data, flt_dout, out_rd_en,
    input  in_rd_en, flt_din, flt_en, out_data, out_valid, out_empty, out_count, frame_done
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, flt_dout, out_rd_en,
    output in_rd_en, flt_din, flt_en, out_data, out_valid, out_empty, out_count, frame_done
  );
endinterface

// File: rtl/gaussian_stream_ctrl.sv
// Feeds a shift-register Gaussian core with row-padded pixels, drops its warm-up outputs,
// drains it at end of frame and buffers results in an output FIFO with back-pressure.
module gaussian_stream_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMG_W      = 400,
  parameter int unsigned IMG_H      = 300,
  parameter int unsigned PAD_W      = 2,
  parameter int unsigned WARMUP     = 799,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  gaussian_stream_ctrl_if.slave bus
);

  localparam int unsigned ColW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned PadW  = (PAD_W > 1) ? $clog2(PAD_W) : 1;
  localparam int unsigned FlW   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned WarmW = $clog2(WARMUP + 1);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  localparam logic [ColW-1:0]  ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0]  RowLast = RowW'(IMG_H - 1);
  localparam logic [PadW-1:0]  PadLast = PadW'((PAD_W > 0) ? PAD_W - 1 : 0);
  localparam logic [FlW-1:0]   FlLast  = FlW'(WARMUP - 1);
  localparam logic [WarmW-1:0] WarmMax = WarmW'(WARMUP);
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StRun, StPad, StFlush, StDone} state_e;

  state_e           state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [PadW-1:0]  pad_q, pad_d;
  logic [FlW-1:0]   fl_q, fl_d;
  logic [WarmW-1:0] warm_q, warm_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  logic warm, full, stall, adv, fifo_wr, fifo_rd;

  // Stall only looks at the registered count, so out_rd_en never reaches flt_en/in_rd_en.
  always_comb begin
    warm  = (warm_q == WarmMax);
    full  = (cnt_q == CntFull);
    stall = warm & full;
    adv   = 1'b0;
    unique case (state_q)
      StRun:          adv = bus.in_valid & ~stall;
      StPad, StFlush: adv = ~stall;
      default:        adv = 1'b0;
    endcase
    adv     = adv & rst_n;
    fifo_wr = adv & warm;
    fifo_rd = bus.out_rd_en & (cnt_q != '0);
  end

  assign bus.flt_en     = adv;
  assign bus.in_rd_en   = adv & (state_q == StRun);
  assign bus.flt_din    = (rst_n && state_q == StRun) ? bus.in_data : '0;
  assign bus.frame_done = (state_q == StDone);
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_empty  = (cnt_q == '0);
  assign bus.out_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pad_d   = pad_q;
    fl_d    = fl_q;
    warm_d  = warm_q;
    if (adv && !warm) warm_d = warm_q + 1'b1;
    unique case (state_q)
      StRun: begin
        if (adv) begin
          if (col_q == ColLast) begin
            col_d = '0;
            if (PAD_W > 0) begin
              state_d = StPad;
            end else if (row_q == RowLast) begin
              state_d = StFlush;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StPad: begin
        if (adv) begin
          if (pad_q == PadLast) begin
            pad_d = '0;
            if (row_q == RowLast) begin
              state_d = StFlush;
            end else begin
              state_d = StRun;
              row_d   = row_q + 1'b1;
            end
          end else begin
            pad_d = pad_q + 1'b1;
          end
        end
      end
      StFlush: begin
        if (adv) begin
          if (fl_q == FlLast) state_d = StDone;
          else                fl_d    = fl_q + 1'b1;
        end
      end
      StDone: begin
        // Frame boundary: the next frame warms the core up again; FIFO data survives.
        state_d = StRun;
        col_d   = '0;
        row_d   = '0;
        pad_d   = '0;
        fl_d    = '0;
        warm_d  = '0;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      col_q   <= '0;
      row_q   <= '0;
      pad_q   <= '0;
      fl_q    <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pad_q   <= pad_d;
      fl_q    <= fl_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({fifo_wr, fifo_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= bus.flt_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= fifo_rd;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_data_q <= mem[rd_ptr_q];
      end
    end
  end

endmodule
